// File: rtl/alu_share_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arb_if
// Purpose  : Request/result bundle between two ALU requesters and the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_share_arb_if #(
    parameter int WIDTH = 64
);
    logic             req0_valid;
    logic             req0_ready;
    logic [3:0]       req0_ifun;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [3:0]       req1_ifun;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             out_valid;
    logic             out_ready;
    logic             out_tag;
    logic [WIDTH-1:0] out_result;
    logic [2:0]       out_cc;
    logic             out_err;

    modport master (
        output req0_valid, req0_ifun, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_ifun, req1_a, req1_b,
        input  req1_ready,
        input  out_valid, out_tag, out_result, out_cc, out_err,
        output out_ready
    );

    modport slave (
        input  req0_valid, req0_ifun, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_ifun, req1_a, req1_b,
        output req1_ready,
        output out_valid, out_tag, out_result, out_cc, out_err,
        input  out_ready
    );
endinterface
`default_nettype wire

// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arb
// Purpose  : Round-robin sharing of one Y86 ALU between two requesters.
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arb #(
    parameter int WIDTH = 64
) (
    input  wire logic       clk,
    input  wire logic       rst,
    alu_share_arb_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic             r_last_grant;
    logic [3:0]       r_ifun;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_tag;
    logic             r_out_valid;
    logic             r_out_tag;
    logic [WIDTH-1:0] r_out_result;
    logic [2:0]       r_out_cc;
    logic             r_out_err;

    logic             w_any_valid;
    logic             w_grant;
    logic             w_accept;
    logic             w_load_out;
    logic             w_release;

    logic [WIDTH-1:0] w_res;
    logic             w_of;
    logic             w_err;

    assign w_any_valid = bus.req0_valid | bus.req1_valid;
    // Under contention the port that did not win last time goes first.
    assign w_grant = (bus.req0_valid && bus.req1_valid) ? ~r_last_grant : bus.req1_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_any_valid) w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_HOLD;
            S_HOLD:  if (bus.out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_accept       = 1'b0;
        w_load_out     = 1'b0;
        w_release      = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    w_accept       = w_any_valid;
                    bus.req0_ready = w_any_valid && !w_grant;
                    bus.req1_ready = w_any_valid && w_grant;
                end
                S_EXEC:  w_load_out = 1'b1;
                S_HOLD:  w_release  = bus.out_ready;
                default: w_accept   = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_res = '0;
        w_of  = 1'b0;
        w_err = 1'b0;
        case (r_ifun)
            4'd0: begin
                w_res = r_b + r_a;
                w_of  = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
            end
            4'd1: begin
                w_res = r_b - r_a;
                w_of  = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_b[WIDTH-1]);
            end
            4'd2:    w_res = r_b & r_a;
            4'd3:    w_res = r_b ^ r_a;
            default: w_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_ifun       <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_tag        <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_tag    <= 1'b0;
            r_out_result <= '0;
            r_out_cc     <= 3'b000;
            r_out_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_last_grant <= w_grant;
                r_tag        <= w_grant;
                r_ifun       <= w_grant ? bus.req1_ifun : bus.req0_ifun;
                r_a          <= w_grant ? bus.req1_a    : bus.req0_a;
                r_b          <= w_grant ? bus.req1_b    : bus.req0_b;
            end
            if (w_load_out) begin
                r_out_valid  <= 1'b1;
                r_out_tag    <= r_tag;
                r_out_result <= w_res;
                // Illegal functions force all flags low, including ZF.
                r_out_cc     <= w_err ? 3'b000 : {(w_res == '0), w_res[WIDTH-1], w_of};
                r_out_err    <= w_err;
            end
            if (w_release) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.out_tag    = r_out_tag;
    assign bus.out_result = r_out_result;
    assign bus.out_cc     = r_out_cc;
    assign bus.out_err    = r_out_err;
endmodule
`default_nettype wire

// File: tb/tb_alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arb
// Purpose  : Self-checking bench for alu_share_arb (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_arb;
    localparam int WIDTH = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_share_arb_if #(.WIDTH(WIDTH)) bus ();
    alu_share_arb #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic        tag;
        logic [63:0] res;
        logic [2:0]  cc;
        logic        err;
        int          gcyc;
    } exp_t;

    typedef struct {
        logic        port;
        logic [3:0]  ifun;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic [2:0]  cc;
        logic        err;
    } vec_t;

    exp_t sbq[$];
    exp_t pend0, pend1, mon_e;
    vec_t vecs[10];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic prev_ov  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference ALU returning {err, cc[2:0], result}.
    function automatic logic [67:0] model(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        logic        of;
        r  = '0;
        of = 1'b0;
        if (f == 4'd0) begin
            r  = a + b;
            of = (a[63] == b[63]) && (r[63] != a[63]);
        end else if (f == 4'd1) begin
            r  = b - a;
            of = (a[63] != b[63]) && (r[63] != b[63]);
        end else if (f == 4'd2) begin
            r = a & b;
        end else if (f == 4'd3) begin
            r = a ^ b;
        end else begin
            return {1'b1, 3'b000, 64'd0};
        end
        return {1'b0, (r == 64'd0), r[63], of, r};
    endfunction

    task automatic drive(input logic p, input logic [3:0] f, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] res, input logic [2:0] cc, input logic err);
        if (!p) begin
            bus.req0_valid = 1'b1; bus.req0_ifun = f; bus.req0_a = a; bus.req0_b = b;
            pend0.tag = 1'b0; pend0.res = res; pend0.cc = cc; pend0.err = err;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_ifun = f; bus.req1_a = a; bus.req1_b = b;
            pend1.tag = 1'b1; pend1.res = res; pend1.cc = cc; pend1.err = err;
        end
    endtask

    task automatic drive_model(input logic p, input logic [3:0] f, input logic [63:0] a, input logic [63:0] b);
        logic [67:0] m;
        m = model(f, a, b);
        drive(p, f, a, b, m[63:0], m[66:64], m[67]);
    endtask

    task automatic wait_grant(input logic p);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (p ? bus.req1_ready : bus.req0_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("grant_seen", 64'(ok), 64'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain", 64'(ok), 64'd1);
    endtask

    // Grant monitor pushes the driven expectation; result monitor pops on out_valid rise.
    always @(negedge clk) begin
        if (bus.req0_ready || bus.req1_ready) begin
            check("grant_onehot", 64'(bus.req0_ready & bus.req1_ready), '0);
            if (bus.req0_ready) begin
                mon_e      = pend0;
                mon_e.gcyc = cyc;
                sbq.push_back(mon_e);
            end else begin
                mon_e      = pend1;
                mon_e.gcyc = cyc;
                sbq.push_back(mon_e);
            end
        end
        if (bus.out_valid && !prev_ov) begin
            check("sb_nonempty", 64'(sbq.size() > 0), 64'd1);
            if (sbq.size() > 0) begin
                mon_e = sbq.pop_front();
                check("out_tag",    64'(bus.out_tag),    64'(mon_e.tag));
                check("out_result", bus.out_result,      mon_e.res);
                check("out_cc",     64'(bus.out_cc),     64'(mon_e.cc));
                check("out_err",    64'(bus.out_err),    64'(mon_e.err));
                check("latency",    64'(cyc - mon_e.gcyc), 64'd2);
            end
        end
        prev_ov <= bus.out_valid;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] snap_res;
        logic [5:0]  snap_ctl;
        int          last_g;
        logic        g;
        bit          seen, replay;

        vecs[0] = '{1'b0, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 3'b011, 1'b0};
        vecs[1] = '{1'b1, 4'd1, 64'd5, 64'd5, 64'd0, 3'b100, 1'b0};
        vecs[2] = '{1'b1, 4'd1, 64'd1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 3'b001, 1'b0};
        vecs[3] = '{1'b0, 4'd7, 64'hF0, 64'h3C, 64'd0, 3'b000, 1'b1};
        vecs[4] = '{1'b0, 4'd2, 64'hF0, 64'h3C, 64'h30, 3'b000, 1'b0};
        vecs[5] = '{1'b0, 4'd3, 64'hF0, 64'h3C, 64'hCC, 3'b000, 1'b0};
        vecs[6] = '{1'b1, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 3'b100, 1'b0};
        vecs[7] = '{1'b0, 4'd1, 64'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010, 1'b0};
        vecs[8] = '{1'b1, 4'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 3'b101, 1'b0};
        vecs[9] = '{1'b0, 4'd15, 64'd9, 64'd9, 64'd0, 3'b000, 1'b1};

        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_ifun = '0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_ifun = '0; bus.req1_a = '0; bus.req1_b = '0;
        bus.out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        @(negedge clk);
        check("rst_ready0",  64'(bus.req0_ready), '0);
        check("rst_ready1",  64'(bus.req1_ready), '0);
        check("rst_outs",    64'({bus.out_valid, bus.out_tag, bus.out_cc, bus.out_err}), '0);
        check("rst_result",  bus.out_result, '0);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        rst = 1'b0;

        // Table of single operations
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].port, vecs[i].ifun, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].cc, vecs[i].err);
            wait_grant(vecs[i].port);
            @(posedge clk); #1;
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
            wait_idle();
        end

        // Backpressure: result held in HOLD while req0 keeps asking
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        drive_model(1'b0, 4'd0, 64'd2, 64'd3);
        wait_grant(1'b0);
        @(posedge clk); #1;
        drive_model(1'b0, 4'd1, 64'd4, 64'd10);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("bp_valid_seen", 64'(seen), 64'd1);
        snap_res = bus.out_result;
        snap_ctl = {bus.out_valid, bus.out_tag, bus.out_cc, bus.out_err};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_result_stable", bus.out_result, snap_res);
            check("bp_ctl_stable", 64'({bus.out_valid, bus.out_tag, bus.out_cc, bus.out_err}), 64'(snap_ctl));
            check("bp_no_ready", 64'(bus.req0_ready), '0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_no_grant_in_hold", 64'(bus.req0_ready), '0);
        @(negedge clk);
        check("bp_regrant", 64'(bus.req0_ready), 64'd1);
        check("bp_valid_cleared", 64'(bus.out_valid), '0);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        wait_idle();

        // Reset while the accepted operation is in EXEC
        @(posedge clk); #1;
        drive(1'b0, 4'd0, 64'd1, 64'd2, 64'd3, 3'b000, 1'b0);
        wait_grant(1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.req0_valid = 1'b0;
        sbq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_outs",   64'({bus.out_valid, bus.out_tag, bus.out_cc, bus.out_err}), '0);
        check("mid_rst_result", bus.out_result, '0);
        replay = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.out_valid) replay = 1'b1;
        end
        check("mid_rst_no_replay", 64'(replay), '0);

        // Contention: round-robin from port 0 after reset, one result per 3 cycles
        @(posedge clk); #1;
        drive_model(1'b0, 4'($urandom_range(0, 5)), {$urandom, $urandom}, {$urandom, $urandom});
        drive_model(1'b1, 4'($urandom_range(0, 5)), {$urandom, $urandom}, {$urandom, $urandom});
        last_g = 0;
        for (int k = 0; k < 6; k++) begin
            seen = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (bus.req0_ready || bus.req1_ready) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("rr_grant_seen", 64'(seen), 64'd1);
            g = bus.req1_ready;
            check("rr_order", 64'(g), 64'(k % 2));
            if (k > 0) check("rr_spacing", 64'(cyc - last_g), 64'd3);
            last_g = cyc;
            @(posedge clk); #1;
            drive_model(g, 4'($urandom_range(0, 5)), {$urandom, $urandom}, {$urandom, $urandom});
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
